// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit sequencing fetch and execute for the simple CPU datapath.
module control_sequencer #(
  parameter logic [4:0] ADD_OP      = 5'b00011,
  parameter bit         UNDEF_HALTS = 1'b0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        Run,
  output logic        PCout,
  output logic        ZHighout,
  output logic        ZLowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        Cout,
  output logic        MAR_enable,
  output logic        PC_enable,
  output logic        MDR_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Zin,
  output logic        HI_enable,
  output logic        LO_enable,
  output logic        Output_port_enable,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        CON_in,
  output logic        GRA,
  output logic        GRB,
  output logic        GRC,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [15:0] register_enable_signals,
  output logic [4:0]  operation
);
  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, RESET, HALT} state_e;
  state_e state_q, state_d;
  logic [4:0] op;
  logic [7:0] t;
  logic [2:0] last;
  logic alu3, imm, ldi, ld, st, ldx, md, un, br, jr, jal;
  logic op_in, op_out, mfhi, mflo, op_halt, undef;
  logic unused_ir;
  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign alu3    = op >= 5'd3 && op <= 5'd11;
  assign imm     = op >= 5'd12 && op <= 5'd14;
  assign ld      = op == 5'd0;
  assign ldi     = op == 5'd1;
  assign st      = op == 5'd2;
  assign ldx     = ld | ldi | st;
  assign md      = op == 5'd15 || op == 5'd16;
  assign un      = op == 5'd17 || op == 5'd18;
  assign br      = op == 5'd19;
  assign jr      = op == 5'd20;
  assign jal     = op == 5'd21;
  assign op_in   = op == 5'd22;
  assign op_out  = op == 5'd23;
  assign mfhi    = op == 5'd24;
  assign mflo    = op == 5'd25;
  assign op_halt = op == 5'd27;
  assign undef   = op >= 5'd28;
  // One-hot view of T0..T7; all zero in RESET and HALT so every output decodes to 0 there.
  assign t = state_q[3] ? 8'd0 : 8'd1 << state_q[2:0];
  assign last = (ld | st) ? 3'd7 :
                (md | br) ? 3'd6 :
                (alu3 | imm | ldi) ? 3'd5 :
                (un | jal) ? 3'd4 :
                (jr | op_in | op_out | mfhi | mflo) ? 3'd3 : 3'd2;
  always_ff @(posedge clock or negedge clear)
    if (!clear) state_q <= RESET;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (state_q == RESET) state_d = T0;
    else if (state_q == HALT) state_d = HALT;
    else if (t[2] && (op_halt || (undef && UNDEF_HALTS))) state_d = HALT;
    else if (state_q[2:0] == last) state_d = Stop ? HALT : T0;
    else state_d = state_e'(state_q + 4'd1);
  end
  assign Run                = !state_q[3];
  assign PCout              = t[0] | (t[3] & jal) | (t[4] & br);
  assign ZHighout           = t[6] & md;
  assign ZLowout            = (t[4] & un) | (t[5] & (alu3 | imm | ldx | md)) | (t[6] & br);
  assign MDRout             = t[2] | (t[7] & ld);
  assign HIout              = t[3] & mfhi;
  assign LOout              = t[3] & mflo;
  assign InPortout          = t[3] & op_in;
  assign Cout               = (t[4] & (imm | ldx)) | (t[5] & br);
  assign MAR_enable         = t[0] | (t[5] & (ld | st));
  assign PC_enable          = (t[3] & jr) | (t[4] & jal) | (t[6] & br & CON_FF);
  assign MDR_enable         = t[1] | (t[6] & (ld | st));
  assign IR_enable          = t[2];
  assign Y_enable           = (t[3] & (alu3 | imm | ldx | md)) | (t[4] & br);
  assign Zin                = (t[3] & un) | (t[4] & (alu3 | imm | ldx | md)) | (t[5] & br);
  assign HI_enable          = t[6] & md;
  assign LO_enable          = t[5] & md;
  assign Output_port_enable = t[3] & op_out;
  assign IncPC              = t[0];
  assign Read               = t[1] | (t[6] & ld);
  assign Write              = t[7] & st;
  assign CON_in             = t[3] & br;
  assign GRA                = (t[3] & (md | br | jr | op_in | op_out | mfhi | mflo)) | (t[4] & (un | jal)) |
                              (t[5] & (alu3 | imm | ldi)) | (t[6] & st) | (t[7] & ld);
  assign GRB                = (t[3] & (alu3 | imm | ldx | un)) | (t[4] & md);
  assign GRC                = t[4] & alu3;
  assign Rin                = (t[3] & (op_in | mfhi | mflo)) | (t[4] & un) | (t[5] & (alu3 | imm | ldi)) | (t[7] & ld);
  assign Rout               = (t[3] & (alu3 | imm | md | un | br | jr | op_out)) | (t[4] & (alu3 | md | jal)) | (t[6] & st);
  assign BAout              = t[3] & ldx;
  assign register_enable_signals = {t[3] & jal, 15'd0};
  assign operation = ((t[4] & (alu3 | imm | md)) | (t[3] & un)) ? op :
                     ((t[4] & ldx) | (t[5] & br)) ? ADD_OP : 5'd0;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench; per-cycle expected control vectors are queued with the instruction that drives them.
module tb_control_sequencer;
  logic clock = 1'b0, clear = 1'b1, CON_FF = 1'b0, Stop = 1'b0;
  logic [31:0] IR = 32'd0;
  logic Run, PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortout, Cout;
  logic MAR_enable, PC_enable, MDR_enable, IR_enable, Y_enable, Zin, HI_enable, LO_enable, Output_port_enable;
  logic IncPC, Read, Write, CON_in, GRA, GRB, GRC, Rin, Rout, BAout;
  logic [15:0] register_enable_signals;
  logic [4:0] operation;
  logic [48:0] obs;
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] ir; logic con; logic [48:0] exp;} entry_t;
  entry_t sb[$];
  localparam logic [48:0] E_RUN = 49'd1 << 48, E_PCO = 49'd1 << 47, E_ZHO = 49'd1 << 46, E_ZLO = 49'd1 << 45;
  localparam logic [48:0] E_MDRO = 49'd1 << 44, E_HIO = 49'd1 << 43, E_LOO = 49'd1 << 42, E_INP = 49'd1 << 41;
  localparam logic [48:0] E_COUT = 49'd1 << 40, E_MARE = 49'd1 << 39, E_PCE = 49'd1 << 38, E_MDRE = 49'd1 << 37;
  localparam logic [48:0] E_IRE = 49'd1 << 36, E_YE = 49'd1 << 35, E_ZIN = 49'd1 << 34, E_HIE = 49'd1 << 33;
  localparam logic [48:0] E_LOE = 49'd1 << 32, E_OPE = 49'd1 << 31, E_INC = 49'd1 << 30, E_RD = 49'd1 << 29;
  localparam logic [48:0] E_WR = 49'd1 << 28, E_CONI = 49'd1 << 27, E_GRA = 49'd1 << 26, E_GRB = 49'd1 << 25;
  localparam logic [48:0] E_GRC = 49'd1 << 24, E_RIN = 49'd1 << 23, E_ROUT = 49'd1 << 22, E_BA = 49'd1 << 21;
  localparam logic [48:0] E_R15 = 49'd1 << 20;
  logic [4:0]  ss_op  [5] = '{5'b10100, 5'b10110, 5'b10111, 5'b11000, 5'b11001};
  logic [48:0] ss_exp [5] = '{E_GRA | E_ROUT | E_PCE, E_INP | E_GRA | E_RIN, E_GRA | E_ROUT | E_OPE,
                              E_HIO | E_GRA | E_RIN, E_LOO | E_GRA | E_RIN};

  control_sequencer dut (
    .clock(clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop), .Run(Run),
    .PCout(PCout), .ZHighout(ZHighout), .ZLowout(ZLowout), .MDRout(MDRout), .HIout(HIout), .LOout(LOout),
    .InPortout(InPortout), .Cout(Cout), .MAR_enable(MAR_enable), .PC_enable(PC_enable),
    .MDR_enable(MDR_enable), .IR_enable(IR_enable), .Y_enable(Y_enable), .Zin(Zin),
    .HI_enable(HI_enable), .LO_enable(LO_enable), .Output_port_enable(Output_port_enable),
    .IncPC(IncPC), .Read(Read), .Write(Write), .CON_in(CON_in), .GRA(GRA), .GRB(GRB), .GRC(GRC),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .register_enable_signals(register_enable_signals),
    .operation(operation)
  );

  always #5 clock = ~clock;
  assign obs = {Run, PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortout, Cout, MAR_enable, PC_enable,
                MDR_enable, IR_enable, Y_enable, Zin, HI_enable, LO_enable, Output_port_enable, IncPC, Read,
                Write, CON_in, GRA, GRB, GRC, Rin, Rout, BAout, register_enable_signals, operation};

  task automatic px(input logic [4:0] o, input logic c, input logic [48:0] e);
    sb.push_back('{{o, 27'd0}, c, E_RUN | e});
  endtask
  task automatic pz(input logic [4:0] o);
    sb.push_back('{{o, 27'd0}, 1'b0, 49'd0});
  endtask
  task automatic pf(input logic [4:0] o);
    px(o, 1'b0, E_PCO | E_MARE | E_INC);
    px(o, 1'b0, E_RD | E_MDRE);
    px(o, 1'b0, E_MDRO | E_IRE);
  endtask
  task automatic push_ld(input logic [4:0] o);
    pf(o);
    px(o, 1'b0, E_GRB | E_BA | E_YE);
    px(o, 1'b0, E_COUT | E_ZIN | 49'd3);
    px(o, 1'b0, E_ZLO | E_MARE);
  endtask
  task automatic do_reset();
    clear = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    entry_t e;
    #2 clear = 1'b0;
    @(negedge clock);
    repeat (3) pz(5'b11010);
    while (sb.size() > 0) begin
      e = sb.pop_front(); IR = e.ir; CON_FF = e.con; #1;
      checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL reset: got %h expected %h", obs, e.exp); end
      @(negedge clock);
    end
    clear = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_alu();
    entry_t e;
    pf(5'b00011);
    px(5'b00011, 1'b0, E_GRB | E_ROUT | E_YE);
    px(5'b00011, 1'b0, E_GRC | E_ROUT | E_ZIN | 49'd3);
    px(5'b00011, 1'b0, E_ZLO | E_GRA | E_RIN);
    pf(5'b01100);
    px(5'b01100, 1'b0, E_GRB | E_ROUT | E_YE);
    px(5'b01100, 1'b0, E_COUT | E_ZIN | 49'd12);
    px(5'b01100, 1'b0, E_ZLO | E_GRA | E_RIN);
    pf(5'b10001);
    px(5'b10001, 1'b0, E_GRB | E_ROUT | E_ZIN | 49'd17);
    px(5'b10001, 1'b0, E_ZLO | E_GRA | E_RIN);
    while (sb.size() > 0) begin
      e = sb.pop_front(); IR = e.ir; CON_FF = e.con; #1;
      checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL alu op=%b: got %h expected %h", e.ir[31:27], obs, e.exp); end
      checks++;
      if ($countones(obs[47:40]) > 1) begin errors++; $display("FAIL alu bus: got %b expected one-hot or zero", obs[47:40]); end
      @(negedge clock);
    end
  endtask

  task automatic test_load_store();
    entry_t e;
    push_ld(5'b00000);
    px(5'b00000, 1'b0, E_RD | E_MDRE);
    px(5'b00000, 1'b0, E_MDRO | E_GRA | E_RIN);
    push_ld(5'b00010);
    px(5'b00010, 1'b0, E_GRA | E_ROUT | E_MDRE);
    px(5'b00010, 1'b0, E_WR);
    pf(5'b00001);
    px(5'b00001, 1'b0, E_GRB | E_BA | E_YE);
    px(5'b00001, 1'b0, E_COUT | E_ZIN | 49'd3);
    px(5'b00001, 1'b0, E_ZLO | E_GRA | E_RIN);
    while (sb.size() > 0) begin
      e = sb.pop_front(); IR = e.ir; CON_FF = e.con; #1;
      checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL ldst op=%b: got %h expected %h", e.ir[31:27], obs, e.exp); end
      checks++;
      if ($countones(obs[47:40]) > 1) begin errors++; $display("FAIL ldst bus: got %b expected one-hot or zero", obs[47:40]); end
      @(negedge clock);
    end
  endtask

  task automatic test_branch();
    entry_t e;
    for (int c = 1; c >= 0; c--) begin
      pf(5'b10011);
      px(5'b10011, c[0], E_GRA | E_ROUT | E_CONI);
      px(5'b10011, c[0], E_PCO | E_YE);
      px(5'b10011, c[0], E_COUT | E_ZIN | 49'd3);
      px(5'b10011, c[0], E_ZLO | (c[0] ? E_PCE : 49'd0));
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); IR = e.ir; CON_FF = e.con; #1;
      checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL branch con=%0d: got %h expected %h", e.con, obs, e.exp); end
      checks++;
      if ($countones(obs[47:40]) > 1) begin errors++; $display("FAIL branch bus: got %b expected one-hot or zero", obs[47:40]); end
      @(negedge clock);
    end
    CON_FF = 1'b0;
  endtask

  task automatic test_short_ops();
    entry_t e;
    for (int i = 0; i < 5; i++) begin
      pf(ss_op[i]);
      px(ss_op[i], 1'b0, ss_exp[i]);
    end
    pf(5'b10101);
    px(5'b10101, 1'b0, E_PCO | E_R15);
    px(5'b10101, 1'b0, E_GRA | E_ROUT | E_PCE);
    pf(5'b11010);
    pf(5'b11100);
    pf(5'b11111);
    while (sb.size() > 0) begin
      e = sb.pop_front(); IR = e.ir; CON_FF = e.con; #1;
      checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL short op=%b: got %h expected %h", e.ir[31:27], obs, e.exp); end
      checks++;
      if ($countones(obs[47:40]) > 1) begin errors++; $display("FAIL short bus: got %b expected one-hot or zero", obs[47:40]); end
      @(negedge clock);
    end
  endtask

  task automatic test_clear_mid_ld();
    entry_t e;
    push_ld(5'b00000);
    while (sb.size() > 0) begin
      e = sb.pop_front(); IR = e.ir; CON_FF = e.con; #1;
      checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL clr_pre: got %h expected %h", obs, e.exp); end
      @(negedge clock);
    end
    #1 checks++;
    if (obs !== (E_RUN | E_RD | E_MDRE)) begin errors++; $display("FAIL clr_t6: got %h expected %h", obs, E_RUN | E_RD | E_MDRE); end
    #1 clear = 1'b0;
    #1 checks++;
    if (obs !== 49'd0) begin errors++; $display("FAIL clr_async: got %h expected 0", obs); end
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    push_ld(5'b00000);
    px(5'b00000, 1'b0, E_RD | E_MDRE);
    px(5'b00000, 1'b0, E_MDRO | E_GRA | E_RIN);
    while (sb.size() > 0) begin
      e = sb.pop_front(); IR = e.ir; CON_FF = e.con; #1;
      checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL clr_restart: got %h expected %h", obs, e.exp); end
      @(negedge clock);
    end
  endtask

  task automatic test_stop_mul();
    entry_t e;
    int i = 0;
    pf(5'b10000);
    px(5'b10000, 1'b0, E_GRA | E_ROUT | E_YE);
    px(5'b10000, 1'b0, E_GRB | E_ROUT | E_ZIN | 49'd16);
    px(5'b10000, 1'b0, E_ZLO | E_LOE);
    px(5'b10000, 1'b0, E_ZHO | E_HIE);
    repeat (4) pz(5'b10000);
    while (sb.size() > 0) begin
      if (i == 4) Stop = 1'b1;
      e = sb.pop_front(); IR = e.ir; CON_FF = e.con; #1;
      checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL stop step %0d: got %h expected %h", i, obs, e.exp); end
      i++;
      @(negedge clock);
    end
    Stop = 1'b0;
    do_reset();
  endtask

  task automatic test_halt();
    entry_t e;
    pf(5'b11011);
    repeat (20) pz(5'b11011);
    while (sb.size() > 0) begin
      e = sb.pop_front(); IR = e.ir; CON_FF = e.con; #1;
      checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL halt: got %h expected %h", obs, e.exp); end
      @(negedge clock);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_short_ops();
    test_clear_mid_ld();
    test_stop_mul();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
